// File: rtl/wb_reg_slave.sv
// Wishbone pipelined register slave: ID, LED, button status, write counter, scratch.
// Define WB_REG_SLAVE_ERR_EN to answer out-of-range accesses with err instead of ack.
module wb_reg_slave #(
    parameter int          NREGS    = 8,
    parameter logic [31:0] ID_VALUE = 32'h5742_0001,
    parameter int          LED_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [29:0]      i_wb_addr,
    input  logic [31:0]      i_wb_data,
    input  logic [3:0]       i_wb_sel,
    output logic             o_wb_stall,
    output logic             o_wb_ack,
    output logic             o_wb_err,
    output logic [31:0]      o_wb_data,
    input  logic             i_button,
    output logic [LED_W-1:0] o_leds
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] IDX_ID   = AW'(0);
    localparam logic [AW-1:0] IDX_LED  = AW'(1);
    localparam logic [AW-1:0] IDX_BTN  = AW'(2);
    localparam logic [AW-1:0] IDX_WCNT = AW'(3);

`ifdef WB_REG_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] din,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = din[8*b +: 8];
        return r;
    endfunction

    logic [AW-1:0]    idx;
    logic             in_range;
    logic             accept;
    logic             wr;
    logic [LED_W-1:0] led_q;
    logic [31:0]      wcnt;
    logic [31:0]      scr [NREGS];
    logic             btn_meta, btn_sync, btn_prev;
    logic             btn_flag;
    logic             btn_rise;
    logic             btn_clr;
    logic [31:0]      rdata;
    logic [31:0]      led_new;
    logic             ack_q, err_q;
    logic [31:0]      data_q;

    assign idx      = i_wb_addr[AW-1:0];
    assign in_range = ~|i_wb_addr[29:AW];
    assign accept   = i_wb_cyc & i_wb_stb;
    assign wr       = accept & i_wb_we & in_range;
    assign btn_rise = btn_sync & ~btn_prev;
    assign btn_clr  = wr & (idx == IDX_BTN) & i_wb_sel[0] & i_wb_data[1];
    assign led_new  = merge(32'(led_q), i_wb_data, i_wb_sel);

    // Combinational read reflects writes committed at the previous edge
    always_comb begin
        rdata = '0;
        if (in_range) begin
            if (idx == IDX_ID)
                rdata = ID_VALUE;
            else if (idx == IDX_LED)
                rdata = 32'(led_q);
            else if (idx == IDX_BTN)
                rdata = {30'd0, btn_flag, btn_sync};
            else if (idx == IDX_WCNT)
                rdata = wcnt;
            else
                rdata = scr[idx];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            led_q    <= '0;
            wcnt     <= '0;
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
            btn_flag <= 1'b0;
            for (int i = 0; i < NREGS; i++) scr[i] <= '0;
        end else begin
            btn_meta <= i_button;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
            btn_flag <= btn_rise | (btn_flag & ~btn_clr);
            if (wr && idx == IDX_LED)
                led_q <= led_new[LED_W-1:0];
            if (wr && idx >= AW'(4))
                scr[idx] <= merge(scr[idx], i_wb_data, i_wb_sel);
            if (wr && idx == IDX_WCNT) begin
                if (|i_wb_sel) wcnt <= merge(wcnt, 32'd0, i_wb_sel);
            end else if (wr) begin
                wcnt <= wcnt + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ack_q  <= accept & (in_range | ~ERR_EN);
            err_q  <= accept & ~in_range & ERR_EN;
            data_q <= (accept & ~i_wb_we) ? rdata : 32'd0;
        end
    end

    // Dropping cyc in the response cycle aborts the answer
    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = ack_q & i_wb_cyc;
    assign o_wb_data  = o_wb_ack ? data_q : 32'd0;
    assign o_leds     = led_q;

`ifdef WB_REG_SLAVE_ERR_EN
    assign o_wb_err = err_q & i_wb_cyc;
`else
    assign o_wb_err = 1'b0;
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: doc/wb_reg_slave.md
Name: wb_reg_slave

Overview:
- Wishbone pipelined-mode responder: the slave end of the bus driven by the UART-command Wishbone master.
- Holds a small memory-mapped register file: ID, LED control, button status, write counter, scratch.
- Answers every accepted request with exactly one ack or err one cycle later.
- Drives board LEDs; samples the user button.

Parameters:
- NREGS, 8, number of 32-bit word registers (power of two, minimum 8)
- ID_VALUE, 32'h5742_0001, read-only value of register 0
- LED_W, 8, width of o_leds

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_wb_cyc  in  1  bus cycle valid
- i_wb_stb  in  1  request strobe
- i_wb_we  in  1  1 = write, 0 = read
- i_wb_addr  in  30  word address
- i_wb_data  in  32  write data
- i_wb_sel  in  4  byte enables, bit n covers data[8n+7:8n]
- o_wb_stall  out  1  request not accepted this cycle
- o_wb_ack  out  1  successful completion
- o_wb_err  out  1  error completion
- o_wb_data  out  32  read data, valid with ack
- i_button  in  1  asynchronous user button, active-high
- o_leds  out  LED_W  LED drive

Behaviour:
- One clock: i_clk. Reset: i_reset_n, asynchronous, active-low.
- Reset values: o_wb_ack=0, o_wb_err=0, o_wb_data=0, o_leds=0, all registers 0 (except the constant ID), synchronizer flops 0.
- o_wb_stall is constant 0. Back-to-back requests are accepted every cycle.
- Accept condition: accept = i_wb_cyc & i_wb_stb.
- Response timing:
  - The cycle after accept, exactly one of o_wb_ack / o_wb_err is high for one cycle.
  - N accepted requests produce N responses, in order.
- Abort: if i_wb_cyc is low in the response cycle, ack/err are forced 0 and the response is dropped. A write still takes effect.
- Address decode:
  - idx = i_wb_addr[log2(NREGS)-1:0].
  - Out of range when any i_wb_addr bit above idx is 1.
- Register map:
  - 0 ID: read-only (ID_VALUE). Writes are acked and ignored.
  - 1 LED: bits [LED_W-1:0] are R/W and drive o_leds directly from the register. Upper bits read 0.
  - 2 BTN:
    - bit0 = synchronized button level, read-only.
    - bit1 = sticky press flag, set on a synchronized 0->1 edge. Write 1 to bit1 with sel[0] set to clear it.
    - A set and a clear in the same cycle: set wins.
  - 3 WCNT:
    - Counts accepted writes to any in-range address, wrapping at 2^32.
    - Any write to WCNT loads 0. That write itself is not counted.
  - 4..NREGS-1 SCRATCH: plain R/W.
- Button input: 2-flop synchronizer, plus a third flop for edge detect. Press-to-bit1 latency is 3 cycles.
- Byte enables:
  - Only bytes with i_wb_sel set are written (LED, SCRATCH, WCNT load).
  - sel=0 on a write is still acked.
  - For WCNT, a sel=0 write neither loads nor counts.
- Read data:
  - Registered at accept, presented with ack.
  - A read in the cycle after a write to the same address returns the new value.
  - o_wb_data is 0 when not acking.
- Reset mid-transaction clears a pending ack/err immediately. Requests in flight are lost.

Optional Feature:
- Macro: WB_REG_SLAVE_ERR_EN.
- Defined: an out-of-range access returns o_wb_err=1, o_wb_ack=0. Writes have no effect and are not counted.
- Undefined: an out-of-range access returns o_wb_ack=1 with o_wb_data=0, and writes are ignored. o_wb_err is tied 0.

Test Plan:
- Reset, then read addr 0 -> ack exactly 1 cycle after accept, o_wb_data=32'h5742_0001, o_wb_err=0.
- Write addr 1 data 32'h0000_00A5 sel 4'b0001 -> o_leds=8'hA5 the cycle after accept. Read addr 1 -> 32'h0000_00A5. Read WCNT -> 1.
- Back-to-back pipelined stb: write addr 4 = 32'hDEAD_BEEF with sel 4'b1100, then read addr 4 -> two consecutive acks, read returns 32'hDEAD_0000.
- Pulse i_button high for 5 cycles -> BTN bit1=1 from cycle 3. Write addr 2 data 2 -> bit1 reads 0. Press during the clear cycle -> bit1 stays 1.
- Read addr 30'h100:
  - With WB_REG_SLAVE_ERR_EN: err pulse, no ack.
  - Without: ack, data 0.
  - Then drop i_wb_cyc in the response cycle of a read to addr 0 -> no ack or err.
- Assert i_reset_n=0 in the cycle after accepting a read -> ack never asserts, o_leds=0, WCNT reads 0 after reset.
